ser_addsub_n: RTL and testbench

Parametrised bit-serial adder/subtractor: the next generation of the team's serial adder. It accepts two WIDTH-bit operands with a start pulse and processes one bit per clock, LSB first, through a single full-adder slice and a registered carry. It presents each sum bit as it is produced and assembles the parallel result with carry-out and signed-overflow flags. It sits beside datapath units that trade latency for area and talks to its controller through a start/busy/done handshake.

---
 rtl/ser_addsub_n.sv | 134 +++++++++++++
 tb/tb_ser_addsub_n.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ser_addsub_n.sv
// ser_addsub_n -- bit-serial adder/subtractor, LSB first, one bit per clock.
//
// A single full-adder slice with a registered carry walks through two
// WIDTH-bit operands. Each sum bit is shown on o_sum_bit as it is produced,
// and the parallel result plus carry-out and signed-overflow flags are
// presented together with a one-cycle o_done pulse.
//
// Ports:
//   i_clk        clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_start      request a new operation (taken only while o_busy=0)
//   i_sub        0: a+b, 1: a-b (captured with i_start)
//   i_a, i_b     operands (captured with i_start)
//   o_busy       high for exactly WIDTH cycles per operation
//   o_sum_bit    current serial sum bit
//   o_sum_valid  o_sum_bit is meaningful (same as o_busy)
//   o_done       one-cycle pulse; o_result/o_cout/o_ovf valid
//   o_result     parallel sum/difference, held until the next op completes
//   o_cout       final carry-out (subtract: 1 = no borrow)
//   o_ovf        two's-complement overflow
//
// state | meaning
// IDLE  | waiting for i_start; o_done may be pulsing for the previous op
// RUN   | one operand bit pair consumed per clock

module ser_addsub_n #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_sum_bit,
  output logic             o_sum_valid,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  // Only WIDTH-1 bits need to be kept: the final sum bit goes straight
  // into o_result on the last edge.
  logic [WIDTH-2:0] r_sh;
  logic             r_done;

  logic             w_s;
  logic             w_cy;
  logic             w_last;

  assign {w_cy, w_s} = {1'b0, r_a[0]} + {1'b0, r_b[0]} + {1'b0, r_c};
  assign w_last      = (r_cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (i_start) w_next_state = RUN;
      RUN:  if (w_last)  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic; sum bit is gated so it reads 0 outside RUN
  always_comb begin
    o_busy      = (r_state == RUN);
    o_sum_valid = (r_state == RUN);
    o_sum_bit   = (r_state == RUN) & w_s;
    o_done      = r_done;
  end

  // Datapath
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      r_sh     <= '0;
      r_done   <= 1'b0;
      o_result <= '0;
      o_cout   <= 1'b0;
      o_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            // Subtraction as a + ~b + 1: invert b, seed carry with 1.
            r_a   <= i_a;
            r_b   <= i_sub ? ~i_b : i_b;
            r_c   <= i_sub;
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_c   <= w_cy;
          r_cnt <= r_cnt + CW'(1);
          r_sh  <= (WIDTH-1)'({w_s, r_sh} >> 1);
          if (w_last) begin
            o_result <= {w_s, r_sh};
            o_cout   <= w_cy;
            // r_c is the carry into the MSB on this last bit.
            o_ovf    <= r_c ^ w_cy;
            r_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ser_addsub_n.sv
module tb_ser_addsub_n;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start16, start8;
  logic        sub;
  logic [15:0] a, b;

  logic        busy16, sbit16, sval16, done16, cout16, ovf16;
  logic [15:0] result16;
  logic        busy8, sbit8, sval8, done8, cout8, ovf8;
  logic [7:0]  result8;

  int n_checks = 0;
  int n_errors = 0;

  ser_addsub_n #(.WIDTH(16)) dut16 (
    .i_clk(clk), .i_reset(rst), .i_start(start16), .i_sub(sub),
    .i_a(a), .i_b(b),
    .o_busy(busy16), .o_sum_bit(sbit16), .o_sum_valid(sval16),
    .o_done(done16), .o_result(result16), .o_cout(cout16), .o_ovf(ovf16)
  );

  ser_addsub_n #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_reset(rst), .i_start(start8), .i_sub(sub),
    .i_a(a[7:0]), .i_b(b[7:0]),
    .o_busy(busy8), .o_sum_bit(sbit8), .o_sum_valid(sval8),
    .o_done(done8), .o_result(result8), .o_cout(cout8), .o_ovf(ovf8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit values.
  function automatic void model(input int w, input logic [63:0] ma, input logic [63:0] mb,
                                input logic msub, output logic [63:0] r,
                                output logic co, output logic ov);
    logic [63:0] mask, aa, bb, full;
    logic sa, sb, sr;
    mask = (64'd1 << w) - 64'd1;
    aa   = ma & mask;
    bb   = mb & mask;
    full = msub ? (aa + ((~bb) & mask) + 64'd1) : (aa + bb);
    r    = full & mask;
    co   = full[w];
    sa   = aa[w-1];
    sb   = bb[w-1];
    sr   = r[w-1];
    ov   = msub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
  endfunction

  function automatic logic [63:0] pick(input int w, input logic [63:0] v16, input logic [63:0] v8);
    return (w == 16) ? v16 : v8;
  endfunction

  // Presents start now (just after an edge), runs w cycles checking every
  // serial bit, and returns in the done cycle after checking the results.
  // glitch >= 0 raises start with other operands during that busy cycle.
  task automatic run_op(input int w, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tsub, input int glitch);
    logic [63:0] er;
    logic eco, eov;
    model(w, {48'd0, ta}, {48'd0, tb_}, tsub, er, eco, eov);
    a = ta; b = tb_; sub = tsub;
    if (w == 16) start16 = 1'b1; else start8 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0; start8 = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    for (int i = 0; i < w; i++) begin
      if (i == glitch) begin
        if (w == 16) start16 = 1'b1; else start8 = 1'b1;
        a = ~ta; b = ta;
      end else begin
        start16 = 1'b0; start8 = 1'b0;
      end
      check("busy",      pick(w, 64'(busy16), 64'(busy8)), 64'd1);
      check("sum_valid", pick(w, 64'(sval16), 64'(sval8)), 64'd1);
      check("done_early", pick(w, 64'(done16), 64'(done8)), 64'd0);
      check("sum_bit",   pick(w, 64'(sbit16), 64'(sbit8)), 64'(er[i]));
      @(posedge clk); #1;
    end
    start16 = 1'b0; start8 = 1'b0;
    check("done",      pick(w, 64'(done16), 64'(done8)), 64'd1);
    check("busy_done", pick(w, 64'(busy16), 64'(busy8)), 64'd0);
    check("result",    pick(w, 64'(result16), 64'(result8)), er);
    check("cout",      pick(w, 64'(cout16), 64'(cout8)), 64'(eco));
    check("ovf",       pick(w, 64'(ovf16), 64'(ovf8)), 64'(eov));
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("done_pulse16", 64'(done16), 64'd0);
    check("done_pulse8",  64'(done8),  64'd0);
  endtask

  task automatic check_zero16(input string tag);
    check({tag, "_busy"},   64'(busy16),   64'd0);
    check({tag, "_sbit"},   64'(sbit16),   64'd0);
    check({tag, "_sval"},   64'(sval16),   64'd0);
    check({tag, "_done"},   64'(done16),   64'd0);
    check({tag, "_result"}, 64'(result16), 64'd0);
    check({tag, "_cout"},   64'(cout16),   64'd0);
    check({tag, "_ovf"},    64'(ovf16),    64'd0);
  endtask

  logic [15:0] da [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
  logic [15:0] db [5] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
  logic        ds [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    rst = 1'b1; start16 = 1'b0; start8 = 1'b0; sub = 1'b0; a = '0; b = '0;
    #12;
    check_zero16("rst");
    rst = 1'b0;
    #1;
    check_zero16("post_rst");
    @(posedge clk); #1;

    // Directed cases, including a back-to-back chain for the last two.
    for (int k = 0; k < 5; k++) begin
      run_op(16, da[k], db[k], ds[k], -1);
      if (k != 3) idle_cycle();
    end

    // Start during busy is ignored.
    run_op(16, 16'h1234, 16'h4321, 1'b0, 5);
    idle_cycle();

    // Back-to-back: second start presented in the done cycle.
    run_op(16, 16'hA5A5, 16'h0F0F, 1'b0, -1);
    run_op(16, 16'h0100, 16'h0200, 1'b1, -1);
    idle_cycle();

    // Randomized operations, sometimes back-to-back.
    for (int k = 0; k < 24; k++) begin
      run_op(16, 16'($urandom), 16'($urandom), 1'($urandom), -1);
      if ($urandom_range(1, 0) == 1) idle_cycle();
    end

    // Leave a nonzero result, then reset in the middle of cycle 7 of RUN.
    run_op(16, 16'h8000, 16'h0001, 1'b1, -1);
    idle_cycle();
    a = 16'h1111; b = 16'h2222; sub = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_zero16("async_rst");
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("no_done_after_rst", 64'(done16), 64'd0);
      check("idle_after_rst",    64'(busy16), 64'd0);
    end
    run_op(16, 16'h0001, 16'h0001, 1'b0, -1);
    check("rst_recover_result", 64'(result16), 64'h0002);
    idle_cycle();

    // 8-bit instance.
    run_op(8, 16'h00F0, 16'h0020, 1'b0, -1);
    idle_cycle();
    run_op(8, 16'h007F, 16'h0001, 1'b0, 3);
    idle_cycle();
    for (int k = 0; k < 12; k++) begin
      run_op(8, 16'($urandom), 16'($urandom), 1'($urandom), -1);
      if ($urandom_range(1, 0) == 1) idle_cycle();
    end
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
